// File: rtl/axi4stream_pkg.sv
// Shared definitions for the AXI4-Stream packet FIFO.
// Holds the packed-beat width, the field offsets used to pack and unpack a
// beat into one storage word, and the FIFO operating-mode enum.
package axi4stream_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FIFO_NORMAL = 1'b0,
        FIFO_FLUSH  = 1'b1
    } fifo_mode_e;

    // Stored beat = tdata(8N) + tkeep(N) + tstrb(N) + tid(I) + tdest(D) + tuser(U) + tlast(1)
    function automatic int beat_width(input int n, input int i, input int d, input int u);
        return 10 * n + i + d + u + 1;
    endfunction

    // Field offsets within a packed beat, LSB first in the order listed above
    function automatic int off_keep(input int n);
        return BYTE_W * n;
    endfunction

    function automatic int off_strb(input int n);
        return (BYTE_W + 1) * n;
    endfunction

    function automatic int off_id(input int n);
        return (BYTE_W + 2) * n;
    endfunction

    function automatic int off_dest(input int n, input int i);
        return off_id(n) + i;
    endfunction

    function automatic int off_user(input int n, input int i, input int d);
        return off_dest(n, i) + d;
    endfunction

    function automatic int off_last(input int n, input int i, input int d, input int u);
        return off_user(n, i, d) + u;
    endfunction

endpackage

// File: rtl/axi4stream_fifo_mem.sv
// Beat storage for the packet FIFO: DEPTH x W register array.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset (clears every entry)
//   we, waddr, wdata  synchronous write port
//   raddr, rdata      asynchronous read port
module axi4stream_fifo_mem
    import axi4stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi4stream_packet_fifo.sv
// Store-and-forward AXI4-Stream FIFO. A packet is offered downstream only once
// its TLAST beat is stored; a packet that fills the whole FIFO without a TLAST
// switches the FIFO into cut-through flush mode until that TLAST is read.
// Ports:
//   ACLK, ARESETn                    clock / asynchronous active-low reset
//   s_t*                             upstream AXI4-Stream slave interface
//   m_t*                             downstream AXI4-Stream master interface
//   level                            beats currently stored
//   pkts                             complete packets (stored TLAST beats)
module axi4stream_packet_fifo
    import axi4stream_pkg::*;
#(
    parameter int N     = 4,
    parameter int I     = 1,
    parameter int D     = 1,
    parameter int U     = 1,
    parameter int DEPTH = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [8*N-1:0]             s_tdata,
    input  logic [N-1:0]               s_tkeep,
    input  logic [N-1:0]               s_tstrb,
    input  logic [I-1:0]               s_tid,
    input  logic [D-1:0]               s_tdest,
    input  logic [U-1:0]               s_tuser,
    input  logic                       s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [8*N-1:0]             m_tdata,
    output logic [N-1:0]               m_tkeep,
    output logic [N-1:0]               m_tstrb,
    output logic [I-1:0]               m_tid,
    output logic [D-1:0]               m_tdest,
    output logic [U-1:0]               m_tuser,
    output logic                       m_tlast,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [$clog2(DEPTH+1)-1:0] pkts
);

    localparam int W      = beat_width(N, I, D, U);
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int O_KEEP = off_keep(N);
    localparam int O_STRB = off_strb(N);
    localparam int O_ID   = off_id(N);
    localparam int O_DEST = off_dest(N, I);
    localparam int O_USER = off_user(N, I, D);
    localparam int O_LAST = off_last(N, I, D, U);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkts_q, pkts_d;
    logic          s_tready_q, s_tready_d;
    fifo_mode_e    mode_q, mode_d;

    logic [W-1:0]  wr_beat;
    logic [W-1:0]  rd_beat;
    logic          wr_en, rd_en, wr_last, rd_last;
    logic          empty, full, flush;

    assign wr_beat = {s_tlast, s_tuser, s_tdest, s_tid, s_tstrb, s_tkeep, s_tdata};

    axi4stream_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_beat),
        .raddr (rd_ptr_q),
        .rdata (rd_beat)
    );

    assign m_tdata = rd_beat[O_KEEP-1:0];
    assign m_tkeep = rd_beat[O_STRB-1:O_KEEP];
    assign m_tstrb = rd_beat[O_ID-1:O_STRB];
    assign m_tid   = rd_beat[O_DEST-1:O_ID];
    assign m_tdest = rd_beat[O_USER-1:O_DEST];
    assign m_tuser = rd_beat[O_LAST-1:O_USER];
    assign m_tlast = rd_beat[O_LAST];

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign wr_en   = s_tvalid && s_tready_q;
    assign rd_en   = m_tvalid && m_tready;
    assign wr_last = wr_en && s_tlast;
    assign rd_last = rd_en && m_tlast;

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pkts_q     <= '0;
            s_tready_q <= 1'b0;
            mode_q     <= FIFO_NORMAL;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pkts_q     <= pkts_d;
            s_tready_q <= s_tready_d;
            mode_q     <= mode_d;
        end
    end

    // Mode next state: flush is entered only when the FIFO is full of a single
    // unterminated packet, and left only when that packet's TLAST is read, so
    // m_tvalid can never drop while a beat is being offered.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            FIFO_NORMAL: if (full && (pkts_q == '0)) mode_d = FIFO_FLUSH;
            FIFO_FLUSH:  if (rd_last)                mode_d = FIFO_NORMAL;
            default:                                 mode_d = FIFO_NORMAL;
        endcase
    end

    // Pointers and occupancy counters
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);

        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && rd_en) begin
            level_d = level_q - LW'(1);
        end

        pkts_d = pkts_q;
        if (wr_last && !rd_last) begin
            pkts_d = pkts_q + LW'(1);
        end else if (!wr_last && rd_last) begin
            pkts_d = pkts_q - LW'(1);
        end

        // Registered ready looks at the next level so it falls on the same
        // edge that fills the last entry.
        s_tready_d = (level_d != LW'(DEPTH));
    end

    // Outputs
    always_comb begin
        flush    = (mode_q == FIFO_FLUSH);
        m_tvalid = !empty && ((pkts_q != '0) || flush);
    end

    assign s_tready = s_tready_q;
    assign level    = level_q;
    assign pkts     = pkts_q;

endmodule

// File: tb/tb_axi4stream_packet_fifo.sv
module tb_axi4stream_packet_fifo;

    localparam int N     = 4;
    localparam int I     = 1;
    localparam int D     = 1;
    localparam int U     = 1;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic           last;
        logic [U-1:0]   user;
        logic [D-1:0]   dest;
        logic [I-1:0]   id;
        logic [N-1:0]   strb;
        logic [N-1:0]   keep;
        logic [8*N-1:0] data;
    } beat_t;

    logic           ACLK = 1'b0;
    logic           ARESETn = 1'b0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]   s_tkeep = '0;
    logic [N-1:0]   s_tstrb = '0;
    logic [I-1:0]   s_tid = '0;
    logic [D-1:0]   s_tdest = '0;
    logic [U-1:0]   s_tuser = '0;
    logic           s_tlast = 1'b0;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [8*N-1:0] m_tdata;
    logic [N-1:0]   m_tkeep;
    logic [N-1:0]   m_tstrb;
    logic [I-1:0]   m_tid;
    logic [D-1:0]   m_tdest;
    logic [U-1:0]   m_tuser;
    logic           m_tlast;
    logic [LW-1:0]  level;
    logic [LW-1:0]  pkts;

    always #5 ACLK = ~ACLK;

    axi4stream_packet_fifo #(
        .N(N), .I(I), .D(D), .U(U), .DEPTH(DEPTH)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tstrb  (s_tstrb),
        .s_tid    (s_tid),
        .s_tdest  (s_tdest),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tstrb  (m_tstrb),
        .m_tid    (m_tid),
        .m_tdest  (m_tdest),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .level    (level),
        .pkts     (pkts)
    );

    int    n_assert = 0;
    int    n_fail   = 0;

    // Reference model: the stored beats as a queue, plus flush and ready state
    beat_t model_q[$];
    bit    flush_m   = 1'b0;
    bit    rdy_m     = 1'b0;
    bit    saw_flush = 1'b0;
    int    max_lvl   = 0;
    bit    rand_rdy  = 1'b0;
    bit    rdy_force = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: fixed level or random per cycle
    always @(posedge ACLK) begin
        #1;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Scoreboard: at each falling edge compare the DUT against the model, then
    // apply the handshakes that will happen on the coming rising edge.
    always @(negedge ACLK) begin
        beat_t obs;
        int    cnt;
        int    sz;
        bit    ev, wr, rd;
        if (!ARESETn) begin
            model_q.delete();
            flush_m = 1'b0;
            rdy_m   = 1'b0;
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_s_tready", s_tready, 0);
            chk("rst_level", level, 0);
            chk("rst_pkts", pkts, 0);
            chk("rst_m_tdata", m_tdata, 0);
        end else begin
            cnt = 0;
            foreach (model_q[k]) if (model_q[k].last) cnt++;
            sz = model_q.size();
            ev = (sz != 0) && ((cnt != 0) || flush_m);
            chk("level", level, sz);
            chk("pkts", pkts, cnt);
            chk("m_tvalid", m_tvalid, ev);
            chk("s_tready", s_tready, rdy_m);
            if (ev) begin
                obs = {m_tlast, m_tuser, m_tdest, m_tid, m_tstrb, m_tkeep, m_tdata};
                chk("m_beat", obs, model_q[0]);
            end
            if (m_tvalid && (pkts == 0)) saw_flush = 1'b1;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            wr = s_tvalid && rdy_m;
            rd = ev && m_tready;
            if (rd && model_q[0].last) flush_m = 1'b0;
            else if ((sz == DEPTH) && (cnt == 0)) flush_m = 1'b1;
            if (rd) void'(model_q.pop_front());
            if (wr) model_q.push_back({s_tlast, s_tuser, s_tdest, s_tid, s_tstrb, s_tkeep, s_tdata});
            rdy_m = (model_q.size() != DEPTH);
        end
    end

    function automatic beat_t mk(input logic [31:0] data, input bit last);
        beat_t b;
        b.data = data;
        b.keep = 4'hF;
        b.strb = 4'hF;
        b.id   = 1'b0;
        b.dest = 1'b0;
        b.user = 1'b0;
        b.last = last;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input bit last);
        beat_t b;
        b.data = $urandom;
        b.keep = 4'($urandom);
        b.strb = 4'($urandom);
        b.id   = 1'($urandom);
        b.dest = 1'($urandom);
        b.user = 1'($urandom);
        b.last = last;
        return b;
    endfunction

    // Present one beat from posedge+1 and hold it until accepted
    task automatic send_beat(input beat_t b);
        int t;
        bit acc;
        {s_tlast, s_tuser, s_tdest, s_tid, s_tstrb, s_tkeep, s_tdata} = b;
        s_tvalid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge ACLK);
            acc = s_tready;
            @(posedge ACLK);
            #1;
            t++;
            if (!acc && (t > 3000)) begin
                n_assert++;
                n_fail++;
                $display("FAIL send_timeout: s_tready observed 0 required 1");
                $fatal(1, "upstream handshake never completed");
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while ((level != 0) && (t < 3000)) begin
            @(posedge ACLK);
            #1;
            t++;
        end
        chk(tag, level, 0);
    endtask

    initial begin
        int t;
        int pops;
        int len;

        // 1: reset release
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        chk("t1_ready_at_release", s_tready, 0);
        chk("t1_valid_at_release", m_tvalid, 0);
        @(posedge ACLK);
        #1;
        chk("t1_ready_after_edge", s_tready, 1);
        chk("t1_valid_after_edge", m_tvalid, 0);
        chk("t1_level", level, 0);
        chk("t1_pkts", pkts, 0);

        // 2: single 3-beat packet with m_tready high
        rdy_force = 1'b1;
        send_beat(mk(32'h11, 1'b0));
        chk("t2_valid_beat1", m_tvalid, 0);
        send_beat(mk(32'h22, 1'b0));
        chk("t2_valid_beat2", m_tvalid, 0);
        send_beat(mk(32'h33, 1'b1));
        chk("t2_valid_after_last", m_tvalid, 1);
        chk("t2_pkts_one", pkts, 1);
        chk("t2_first_data", m_tdata, 32'h11);
        wait_drain("t2_drain");
        chk("t2_pkts_zero", pkts, 0);

        // 3: backpressure, 4 packets of 4 beats fill the FIFO
        rdy_force = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 4; b++) begin
                send_beat(rnd_beat(b == 3));
                if ((p == 3) && (b == 2)) chk("t3_ready_beat15", s_tready, 1);
            end
        end
        chk("t3_ready_full", s_tready, 0);
        chk("t3_level_full", level, DEPTH);
        chk("t3_pkts_four", pkts, 4);
        chk("t3_valid_full", m_tvalid, 1);
        rdy_force = 1'b1;
        t = 0;
        @(negedge ACLK);
        while (!(m_tvalid && m_tready) && (t < 10)) begin
            @(negedge ACLK);
            t++;
        end
        pops = (m_tvalid && m_tready) ? 1 : 0;
        repeat (DEPTH - 1) begin
            @(negedge ACLK);
            if (m_tvalid && m_tready) pops++;
        end
        chk("t3_contiguous_pops", pops, DEPTH);
        @(posedge ACLK);
        #1;
        chk("t3_level_empty", level, 0);

        // 4: oversize 20-beat packet forces flush mode
        saw_flush = 1'b0;
        max_lvl   = 0;
        for (int b = 0; b < 20; b++) begin
            send_beat(mk(32'h400 + 32'(b), b == 19));
        end
        wait_drain("t4_drain");
        chk("t4_pkts_zero", pkts, 0);
        chk("t4_saw_flush", saw_flush, 1);
        chk("t4_max_level", max_lvl, DEPTH);
        send_beat(mk(32'hA1, 1'b0));
        chk("t4_flush_cleared", m_tvalid, 0);
        send_beat(mk(32'hA2, 1'b1));
        chk("t4_next_pkt_valid", m_tvalid, 1);
        wait_drain("t4_drain2");

        // 5: TLAST written and TLAST read on the same edge
        rdy_force = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        send_beat(mk(32'h51, 1'b1));
        rdy_force = 1'b1;
        @(posedge ACLK);
        #1;
        {s_tlast, s_tuser, s_tdest, s_tid, s_tstrb, s_tkeep, s_tdata} = mk(32'h52, 1'b1);
        s_tvalid = 1'b1;
        chk("t5_level_before", level, 1);
        chk("t5_pkts_before", pkts, 1);
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0;
        chk("t5_level_after", level, 1);
        chk("t5_pkts_after", pkts, 1);
        chk("t5_head_data", m_tdata, 32'h52);
        wait_drain("t5_drain");

        // 6: reset with a complete packet and a partial packet stored
        rdy_force = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        send_beat(mk(32'h61, 1'b0));
        send_beat(mk(32'h62, 1'b1));
        send_beat(mk(32'h63, 1'b0));
        send_beat(mk(32'h64, 1'b0));
        send_beat(mk(32'h65, 1'b0));
        chk("t6_valid_before", m_tvalid, 1);
        chk("t6_level_before", level, 5);
        chk("t6_pkts_before", pkts, 1);
        ARESETn = 1'b0;
        #1;
        chk("t6_valid_in_reset", m_tvalid, 0);
        chk("t6_level_in_reset", level, 0);
        chk("t6_pkts_in_reset", pkts, 0);
        chk("t6_data_in_reset", m_tdata, 0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        rdy_force = 1'b1;
        chk("t6_ready_at_release", s_tready, 0);
        @(posedge ACLK);
        #1;
        chk("t6_ready_after_edge", s_tready, 1);
        send_beat(mk(32'h71, 1'b0));
        send_beat(mk(32'h72, 1'b0));
        send_beat(mk(32'h73, 1'b1));
        chk("t6_next_pkt_valid", m_tvalid, 1);
        wait_drain("t6_drain");

        // Random packets (1..40 beats) with random m_tready and source gaps
        rand_rdy = 1'b1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 40);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge ACLK);
                    #1;
                end
                send_beat(rnd_beat(b == len - 1));
            end
        end
        wait_drain("rand_drain");
        rand_rdy = 1'b0;
        chk("rand_pkts_zero", pkts, 0);
        chk("rand_model_empty", model_q.size(), 0);

        repeat (2) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
